dmem_access_unit: RTL and testbench

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

---
 rtl/dmem_access_unit.sv | 125 ++++++++++++
 tb/tb_dmem_access_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: decodes icode into a read/write of one DATA_W word,
// runs it against a byte array over LAT cycles and reports valM/stat with sticky stop.
module dmem_access_unit #(
   parameter int DATA_W    = 64,
   parameter int MEM_BYTES = 16384,
   parameter int LAT       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        icode,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valA,
   input  logic [DATA_W-1:0] valP,
   input  logic              instr_valid,
   input  logic              imem_error,
   output logic [DATA_W-1:0] valM,
   output logic [1:0]        stat,
   output logic              busy,
   output logic              done,
   output logic              stopped,
   output logic [1:0]        stateDbg
);
   // Handshake: start is taken only on an edge where busy=0 and stopped=0; done is a
   // one-cycle completion pulse and valM/stat stay valid from then until the next done.
   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(MEM_BYTES);
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [DATA_W-1:0] ADDR_MAX = DATA_W'(MEM_BYTES - NB);
   localparam logic [1:0] S_AOK = 2'd0, S_HLT = 2'd1, S_ADR = 2'd2, S_INS = 2'd3;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;
   stateT state, stateNext;

   logic [7:0]        mem [MEM_BYTES];
   logic [CW-1:0]     latCnt;
   logic              latWrite;
   logic [AW-1:0]     latAddr;
   logic [DATA_W-1:0] latData;
   logic              isWrite, isRead, accept, legal, finish;
   logic [DATA_W-1:0] reqAddr, reqData, rdData;
   logic [1:0]        reqStat;

   always_comb begin
      isWrite = (icode == 4'd4) || (icode == 4'd10) || (icode == 4'd8);
      isRead  = (icode == 4'd5) || (icode == 4'd11) || (icode == 4'd9);
      reqAddr = ((icode == 4'd11) || (icode == 4'd9)) ? valA : valE;
      reqData = (icode == 4'd8) ? valP : valA;
      // Compare against the last legal base address so the check never wraps.
      if (icode == 4'd0)
         reqStat = S_HLT;
      else if (((isWrite || isRead) && (reqAddr > ADDR_MAX)) || imem_error)
         reqStat = S_ADR;
      else if (!instr_valid)
         reqStat = S_INS;
      else
         reqStat = S_AOK;
   end

   assign accept = (state == IDLE) && start && !stopped;
   assign legal  = (isWrite || isRead) && (reqStat == S_AOK);
   assign finish = (state == ACCESS) && (latCnt == CW'(LAT - 1));

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = legal ? ACCESS : DONE;
         ACCESS:  if (finish) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         latCnt   <= '0;
         latWrite <= 1'b0;
         latAddr  <= '0;
         latData  <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            latCnt   <= '0;
            latWrite <= isWrite;
            latAddr  <= reqAddr[AW-1:0];
            latData  <= reqData;
         end else if (state == ACCESS) begin
            latCnt <= latCnt + CW'(1);
         end
      end
   end

   always_comb begin
      rdData = '0;
      for (int i = 0; i < NB; i++)
         rdData[8*i +: 8] = mem[latAddr + AW'(i)];
   end

   // The array has no reset; a reset forces IDLE at once so finish can never fire.
   always_ff @(posedge clk) begin
      if (finish && latWrite)
         for (int i = 0; i < NB; i++)
            mem[latAddr + AW'(i)] <= latData[8*i +: 8];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valM    <= '0;
         stat    <= S_AOK;
         stopped <= 1'b0;
      end else if (accept && !legal) begin
         valM <= '0;
         stat <= reqStat;
         if (reqStat != S_AOK) stopped <= 1'b1;
      end else if (finish) begin
         valM <= latWrite ? '0 : rdData;
         stat <= S_AOK;
      end
   end

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign stateDbg = state;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed and random requests against a byte-level
// reference model; a negedge monitor pops expected valM/stat/latency on every done.
module tb_dmem_access_unit;
   localparam int DATA_W = 64;
   localparam int MEM_BYTES = 16384;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  icode = '0;
   logic [63:0] valE = '0, valA = '0, valP = '0;
   logic        instr_valid = 1'b1, imem_error = 1'b0;
   logic [63:0] valM;
   logic [1:0]  stat;
   logic        busy, done, stopped;
   logic [1:0]  stateDbg;

   dmem_access_unit #(.DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .icode(icode),
      .valE(valE), .valA(valA), .valP(valP),
      .instr_valid(instr_valid), .imem_error(imem_error),
      .valM(valM), .stat(stat), .busy(busy), .done(done), .stopped(stopped),
      .stateDbg(stateDbg)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: byte memory, sticky stop flag
   logic [7:0] refMem [logic [63:0]];
   bit         modelStopped = 0;

   function automatic logic [7:0] refByte(input logic [63:0] a);
      return refMem.exists(a) ? refMem[a] : 8'h00;
   endfunction

   task automatic modelOp(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                          input logic [63:0] p, input logic iv, input logic ie,
                          output logic [63:0] expVal, output logic [1:0] expStat, output int lat);
      bit isWr, isRd;
      logic [63:0] addr, wd;
      isWr = (ic == 4) || (ic == 10) || (ic == 8);
      isRd = (ic == 5) || (ic == 11) || (ic == 9);
      addr = (ic == 11 || ic == 9) ? a : e;
      wd   = (ic == 8) ? p : a;
      if (ic == 0) expStat = 2'd1;
      else if (((isWr || isRd) && ({1'b0, addr} + 65'd8 > 65'(MEM_BYTES))) || ie) expStat = 2'd2;
      else if (!iv) expStat = 2'd3;
      else expStat = 2'd0;
      expVal = '0;
      lat = (expStat == 0 && (isWr || isRd)) ? LAT + 1 : 1;
      if (expStat == 0 && isWr)
         for (int i = 0; i < 8; i++) refMem[addr + 64'(i)] = wd[8*i +: 8];
      if (expStat == 0 && isRd)
         for (int i = 0; i < 8; i++) expVal[8*i +: 8] = refByte(addr + 64'(i));
      if (expStat != 0) modelStopped = 1;
   endtask

   // scoreboard queues
   logic [63:0] expValQ[$];
   logic [1:0]  expStatQ[$];
   int          expCycQ[$];

   always @(negedge clk) begin
      if (rst && done) begin
         if (expValQ.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            logic [63:0] ev;
            logic [1:0]  es;
            int          ec;
            ev = expValQ.pop_front();
            es = expStatQ.pop_front();
            ec = expCycQ.pop_front();
            chk("valM", valM, ev);
            chk("stat", 64'(stat), 64'(es));
            chk("latency", 64'(cyc), 64'(ec));
            chk("stopped_at_done", 64'(stopped), 64'(es != 0));
         end
      end
   end

   // driver tasks
   task automatic issueFull(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                            input logic [63:0] p, input logic iv, input logic ie, input bit track);
      logic [63:0] ev;
      logic [1:0]  es;
      int          lat;
      @(negedge clk);
      icode = ic; valA = a; valE = e; valP = p; instr_valid = iv; imem_error = ie;
      start = 1'b1;
      if (track && !modelStopped) begin
         modelOp(ic, a, e, p, iv, ie, ev, es, lat);
         expValQ.push_back(ev);
         expStatQ.push_back(es);
         expCycQ.push_back(cyc + lat);
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      if (n == 30) chk("idle_timeout", 64'(busy), 64'(0));
   endtask

   task automatic issue(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] p);
      issueFull(ic, a, e, p, 1'b1, 1'b0, 1'b1);
      waitIdle();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      modelStopped = 0;
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, "_valM"}, valM, 64'h0);
      chk({tag, "_stat"}, 64'(stat), 64'h0);
      chk({tag, "_busy"}, 64'(busy), 64'h0);
      chk({tag, "_done"}, 64'(done), 64'h0);
      chk({tag, "_stopped"}, 64'(stopped), 64'h0);
   endtask

   logic [3:0]  nopCodes [8] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd13, 4'd15};
   int          sel;
   logic [63:0] rAddr, rData;

   initial begin
      repeat (3) @(negedge clk);
      #1 chkAllZero("reset");
      @(negedge clk);
      rst = 1'b1;

      // known contents for later reads
      issue(4, 64'h0, 64'h108, 64'h0);
      for (int k = 0; k < 32; k++) issue(4, {$urandom, $urandom}, 64'h400 + 64'(8 * k), 64'h0);

      issue(4, 64'h1122334455667788, 64'h100, 64'h0);
      issue(5, 64'h0, 64'h100, 64'h0);
      issue(5, 64'h0, 64'h101, 64'h0);
      issue(8, 64'h0, 64'h200, 64'hABCD);
      issue(9, 64'h200, 64'h0, 64'h0);
      issue(11, 64'h200, 64'h0, 64'h0);

      for (int n = 0; n < 60; n++) begin
         sel   = $urandom_range(0, 7);
         rAddr = 64'h400 + 64'($urandom_range(0, 248));
         rData = {$urandom, $urandom};
         case (sel)
            0: issue(4, rData, rAddr, 64'h0);
            1: issue(10, rData, rAddr, 64'h0);
            2: issue(8, 64'h0, rAddr, rData);
            3: issue(5, rData, rAddr, 64'h0);
            4: issue(11, rAddr, rData, 64'h0);
            5: issue(9, rAddr, rData, 64'h0);
            default: issue(nopCodes[$urandom_range(0, 7)], rData, rData, rData);
         endcase
      end

      // reset one cycle into an access must abort the write
      issue(4, 64'h55, 64'h300, 64'h0);
      issue(5, 64'h0, 64'h100, 64'h0);
      issueFull(4, 64'hFF, 64'h300, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("abort_in_access", 64'(busy), 64'(1));
      rst = 1'b0;
      #1 chkAllZero("abort");
      @(negedge clk);
      rst = 1'b1;
      modelStopped = 0;
      issue(5, 64'h0, 64'h300, 64'h0);

      // top boundary, then first illegal address
      issue(4, 64'hCAFE, 64'h3FF8, 64'h0);
      issue(4, 64'hBEEF, 64'h3FF9, 64'h0);
      chk("stopped_after_adr", 64'(stopped), 64'(1));
      issueFull(5, 64'h0, 64'h100, 64'h0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("ignored_busy", 64'(busy), 64'(0));
      end
      doReset();
      issue(5, 64'h0, 64'h3FF8, 64'h0);

      issue(0, 64'h0, 64'h0, 64'h0);
      chk("stopped_after_hlt", 64'(stopped), 64'(1));
      doReset();
      issueFull(6, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      waitIdle();
      doReset();
      issueFull(1, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
      waitIdle();
      doReset();
      issueFull(0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
      waitIdle();
      doReset();
      issueFull(5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 1'b0, 1'b1);
      waitIdle();

      repeat (4) @(negedge clk);
      chk("queue_empty", 64'(expValQ.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
